// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-and-add-3 binary to packed BCD, one bit/cycle.
// Ports: clk, reset, start/bin in; busy, done pulse, held bcd/ovf out.
module bin2bcd_seq #(
    parameter int W      = 27,
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [W-1:0]          bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(W + 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] LIMIT   = pow10(DIGITS);
    localparam logic [63:0] BIN_MAX = (64'd1 << W) - 64'd1;
    // Narrow inputs can never reach 10^DIGITS.
    localparam bit          CAN_OVF = (BIN_MAX >= LIMIT);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state, state_nxt;
    logic [W-1:0]    shreg;
    logic [BW-1:0]   scratch;
    logic [BW-1:0]   corr;
    logic [BW-1:0]   scratch_nxt;
    logic [CW-1:0]   cnt;
    logic            ovf_pend;
    logic            ovf_calc;
    logic            last;

    assign ovf_calc = CAN_OVF && (64'(bin) >= LIMIT);
    assign last     = (cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SHIFT);
    end

    // Correct every digit in parallel, then shift the next binary MSB in.
    always_comb begin
        logic [3:0] dig;
        dig  = 4'd0;
        corr = '0;
        for (int i = 0; i < DIGITS; i++) begin
            dig = scratch[4*i +: 4];
            corr[4*i +: 4] = (dig >= 4'd5) ? dig + 4'd3 : dig;
        end
        scratch_nxt = {corr[BW-2:0], shreg[W-1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg    <= '0;
            scratch  <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            bcd      <= '0;
            ovf      <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg    <= bin;
                        scratch  <= '0;
                        cnt      <= CW'(W);
                        ovf_pend <= ovf_calc;
                    end
                end
                SHIFT: begin
                    shreg   <= shreg << 1;
                    scratch <= scratch_nxt;
                    cnt     <= cnt - CW'(1);
                    if (last) begin
                        bcd  <= ovf_pend ? '1 : scratch_nxt;
                        ovf  <= ovf_pend;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench for bin2bcd_seq against a decimal model.
// Drives at negedge, monitors sample at negedge.
module tb_bin2bcd_seq;

    localparam int W  = 27;
    localparam int D  = 8;
    localparam int W2 = 16;
    localparam int D2 = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, start2;
    logic [W-1:0]  bin;
    logic [W2-1:0] bin2;
    logic          busy, done, ovf;
    logic          busy2, done2, ovf2;
    logic [31:0]   bcd;
    logic [15:0]   bcd2;

    bin2bcd_seq #(.W(W), .DIGITS(D)) dut (
        .clk(clk), .reset(reset), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd), .ovf(ovf)
    );

    bin2bcd_seq #(.W(W2), .DIGITS(D2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .bin(bin2),
        .busy(busy2), .done(done2), .bcd(bcd2), .ovf(ovf2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] bcd;
        logic        ovf;
        int          due;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [63:0] lim_of(input int nd);
        logic [63:0] l;
        l = 64'd1;
        for (int i = 0; i < nd; i++) l = l * 64'd10;
        return l;
    endfunction

    function automatic logic ref_ovf(input logic [63:0] v, input int nd);
        return v >= lim_of(nd);
    endfunction

    function automatic logic [31:0] ref_bcd(input logic [63:0] v, input int nd);
        logic [31:0] r;
        logic [63:0] x;
        r = '0;
        x = v;
        for (int i = 0; i < nd; i++) begin
            if (ref_ovf(v, nd)) r[4*i +: 4] = 4'hF;
            else r[4*i +: 4] = 4'(x % 64'd10);
            x = x / 64'd10;
        end
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic flag(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    logic prev_done = 1'b0;
    logic prev_done2 = 1'b0;

    always @(negedge clk) begin : mon1
        exp_t e;
        if (done) begin
            check("busy_with_done", 32'(busy), 32'd0);
            check("done_twice", 32'(prev_done), 32'd0);
            if (q1.size() == 0) begin
                flag("unexpected_done");
            end else begin
                e = q1.pop_front();
                check("bcd", bcd, e.bcd);
                check("ovf", 32'(ovf), 32'(e.ovf));
                check("latency", 32'(cyc), 32'(e.due));
            end
        end else if (q1.size() > 0 && cyc > q1[0].due) begin
            flag("done_timeout");
            void'(q1.pop_front());
        end
        prev_done = done;
    end

    always @(negedge clk) begin : mon2
        exp_t e;
        if (done2) begin
            check("busy2_with_done2", 32'(busy2), 32'd0);
            check("done2_twice", 32'(prev_done2), 32'd0);
            if (q2.size() == 0) begin
                flag("unexpected_done2");
            end else begin
                e = q2.pop_front();
                check("bcd2", {16'd0, bcd2}, e.bcd);
                check("ovf2", 32'(ovf2), 32'(e.ovf));
                check("latency2", 32'(cyc), 32'(e.due));
            end
        end else if (q2.size() > 0 && cyc > q2[0].due) begin
            flag("done2_timeout");
            void'(q2.pop_front());
        end
        prev_done2 = done2;
    end

    task automatic issue(input logic [W-1:0] v);
        exp_t e;
        start = 1'b1;
        bin   = v;
        e.bcd = ref_bcd(64'(v), D);
        e.ovf = ref_ovf(64'(v), D);
        e.due = cyc + W + 1;
        q1.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic issue2(input logic [W2-1:0] v);
        exp_t e;
        start2 = 1'b1;
        bin2   = v;
        e.bcd  = ref_bcd(64'(v), D2);
        e.ovf  = ref_ovf(64'(v), D2);
        e.due  = cyc + W2 + 1;
        q2.push_back(e);
        @(negedge clk);
        start2 = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) return;
        end
        flag("wait_done_timeout");
    endtask

    task automatic wait_done2();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done2) return;
        end
        flag("wait_done2_timeout");
    endtask

    initial begin
        int t0;
        reset  = 1'b1;
        start  = 1'b0;
        start2 = 1'b0;
        bin    = '0;
        bin2   = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_bcd", bcd, 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);

        issue(27'd0);
        wait_done();
        issue(27'd12345678);
        wait_done();
        issue(27'd99999999);
        wait_done();
        issue(27'd100000000);
        wait_done();
        issue(27'h7FFFFFF);
        wait_done();

        // start while busy must be ignored, with bin wiggling underneath
        @(negedge clk);
        t0 = cyc;
        issue(27'd42);
        start = 1'b1;
        bin   = 27'd7;
        while (cyc < t0 + 21) begin
            @(negedge clk);
            if (cyc >= t0 + 5) bin = 27'($urandom);
        end
        start = 1'b0;
        wait_done();
        repeat (5) @(negedge clk);

        // reset in the middle of a conversion
        t0 = cyc;
        issue(27'd555);
        while (cyc < t0 + 10) @(negedge clk);
        reset = 1'b1;
        q1.delete();
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_bcd", bcd, 32'd0);
        check("midrst_ovf", 32'(ovf), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        issue(27'd555);
        wait_done();

        // held result
        issue(27'd1000);
        wait_done();
        repeat (100) begin
            @(negedge clk);
            check("hold_bcd", bcd, 32'h00001000);
            check("hold_ovf", 32'(ovf), 32'd0);
            check("hold_done", 32'(done), 32'd0);
        end

        // random back-to-back
        for (int i = 0; i < 1000; i++) begin
            issue(27'($urandom_range(99999999, 0)));
            wait_done();
        end
        repeat (3) @(negedge clk);

        // narrow configuration
        issue2(16'd9999);
        wait_done2();
        issue2(16'd10000);
        wait_done2();
        issue2(16'd0);
        wait_done2();
        for (int i = 0; i < 20; i++) begin
            issue2(16'($urandom));
            wait_done2();
        end

        repeat (40) @(negedge clk);
        check("q1_drained", 32'(q1.size()), 32'd0);
        check("q2_drained", 32'(q2.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter (shift-and-add-3, one bit per cycle) that turns an unsigned binary value into packed BCD digits for the 8-digit seven-segment driver's 32-bit `data` input. It sits directly upstream of the display driver, so counters and results appear in decimal rather than hex. The converted word is registered and held stable until the next conversion completes. Out-of-range inputs produce an all-`F` pattern.

## Interface
- `W`, 27, width of binary input; legal range 1..32.
- `DIGITS`, 8, number of BCD digits produced; legal range 1..8.
- `clk`  input  1  clock; all logic on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  request a conversion of `bin`; sampled only when idle.
- `bin`  input  W  unsigned binary value; sampled in the cycle `start` is accepted.
- `busy`  output  1  conversion in progress; `start` is ignored while high.
- `done`  output  1  single-cycle pulse; `bcd` and `ovf` were updated this cycle.
- `bcd`  output  4*DIGITS  packed BCD result, digit 0 (least significant) in bits [3:0]; held between conversions.
- `ovf`  output  1  last conversion's input was at least 10^DIGITS; held with `bcd`.

## Operation
- **Interface rule:** one clock `clk`; reset `reset` is synchronous and active-high.
- **Reset values:** every output goes to 0 (`bcd` = 0, so the display shows all zeros). The FSM goes to IDLE.
- **FSM states:**
  - IDLE: `busy`=0. If `start`=1, latch `bin` into the shift register, clear the BCD scratch register, load the bit counter with W, compute the overflow flag, and go to SHIFT.
  - SHIFT: `busy`=1. Each cycle, add 3 to every scratch digit that is >=5. Then shift {scratch, shift register} left by one, so the MSB of the shift register enters bit 0 of the scratch. Decrement the counter.
  - When the counter reaches 1 during a SHIFT cycle, the next state is IDLE. At that same edge, load `bcd` from the final scratch value and pulse `done`.
- **Add-3 timing:** correction and shift are one combinational step per cycle. Correction is applied before the shift, on all DIGITS digits in parallel.
- **Scratch width:** 4*DIGITS bits. Bits shifted out of the top digit are discarded.
- **Overflow:**
  - `ovf_pending` = (`bin` >= 10^DIGITS), evaluated at accept time in at least 64-bit constant arithmetic.
  - If W is too narrow to reach 10^DIGITS, `ovf_pending` is constant 0.
  - On completion, if `ovf_pending`=1, `bcd` is all ones (every digit 4'hF) and `ovf`=1. Otherwise `bcd` is the scratch value and `ovf`=0.
- **`start` while `busy`:** ignored. No queueing, and no effect on the running conversion.
- **`start` in the `done` cycle:** accepted, because the block is already IDLE with `busy`=0. This gives back-to-back conversions with no dead cycle.
- **`bin` changes after accept:** no effect on the running conversion.
- **Reset mid-conversion:** abort with no `done` pulse. `bcd` and `ovf` return to 0.
- **Output stability:** `bcd` and `ovf` change only on the `done` edge or on reset. The display sees no intermediate values.

## Timing
- `start` is sampled high in cycle t (while idle).
- `busy` is 1 in cycles t+1 .. t+W.
- `done`=1 and the new `bcd`/`ovf` are visible in cycle t+W+1, with `busy`=0 in that cycle.
- Total latency from `start` to `done` is W+1 cycles: 28 for the defaults.
- Throughput: one conversion per W+1 cycles.
- `done` is never high for two consecutive cycles.
- `done` and `busy` are never high together.

## Test plan
- **Zero and back-to-back:** reset, then `start` with `bin`=0 → `done` exactly 28 cycles later, `bcd`=32'h00000000, `ovf`=0. Then `start` with `bin`=12345678 in the `done` cycle → 28 cycles later `bcd`=32'h12345678.
- **Boundaries:**
  - `bin`=99999999 → `bcd`=32'h99999999, `ovf`=0.
  - `bin`=100000000 → `bcd`=32'hFFFFFFFF, `ovf`=1.
  - `bin`=2^27-1 → `bcd`=32'hFFFFFFFF, `ovf`=1.
- **Ignored start:** `start` with `bin`=42, then `start` with `bin`=7 and `bin` toggled during cycles t+5..t+20 → a single `done` at t+28 with `bcd`=32'h00000042.
- **Reset mid-conversion:** assert `reset` at cycle t+10 of a conversion of 555 → no `done` pulse, and `busy`, `bcd`, `ovf` are all 0 the following cycle. A fresh `start` with `bin`=555 then yields 32'h00000555.
- **Hold:** after a result of 32'h00001000, hold `start` low for 100 cycles → `bcd` and `ovf` are unchanged and `done` stays 0.
- **Random vs. model:** 1000 random `bin` values in 0..99999999 → `bcd` matches a reference decimal conversion. Also run `DIGITS`=4, `W`=16 with `bin`=9999 → 16'h9999, and `bin`=10000 → 16'hFFFF with `ovf`=1.
